// File: rtl/rotary_encoder_axil_arbiter.sv
// Two-requester round-robin front end that issues one AXI4-Lite transaction at a time
// on behalf of requester 0 or 1 and returns the response with a one-cycle done pulse.
module rotary_encoder_axil_arbiter #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,

  input  logic                            req0_valid,
  input  logic                            req0_write,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   req0_wdata,
  output logic                            req0_done,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   req0_rdata,
  output logic [1:0]                      req0_resp,

  input  logic                            req1_valid,
  input  logic                            req1_write,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   req1_wdata,
  output logic                            req1_done,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   req1_rdata,
  output logic [1:0]                      req1_resp,

  output logic                            busy,

  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

  state_t                          state, state_nxt;
  logic                            gnt;
  logic                            last_grant;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                            aw_pend, w_pend, ar_pend;

  logic                            elig0, elig1, any_req, pick, pick_write;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   pick_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   pick_wdata;
  logic                            aw_ok, w_ok;

  // A requester whose done is pulsing this cycle is still holding valid; mask it so
  // the same request is not granted twice.
  assign elig0   = req0_valid & ~req0_done;
  assign elig1   = req1_valid & ~req1_done;
  assign any_req = elig0 | elig1;

  always_comb begin
    pick = 1'b0;
    if (elig0 && elig1) pick = ~last_grant;
    else                pick = elig1;
  end

  assign pick_write = pick ? req1_write : req0_write;
  assign pick_addr  = pick ? req1_addr  : req0_addr;
  assign pick_wdata = pick ? req1_wdata : req0_wdata;

  assign aw_ok = ~aw_pend | M_AXI_AWREADY;
  assign w_ok  = ~w_pend  | M_AXI_WREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = pick_write ? WR_AW_W : RD_AR;
      WR_AW_W: if (aw_ok && w_ok) state_nxt = WR_B;
      WR_B:    if (M_AXI_BVALID) state_nxt = IDLE;
      RD_AR:   if (M_AXI_ARREADY) state_nxt = RD_R;
      RD_R:    if (M_AXI_RVALID) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    M_AXI_BREADY  = (state == WR_B);
    M_AXI_RREADY  = (state == RD_R);
    M_AXI_AWVALID = aw_pend;
    M_AXI_WVALID  = w_pend;
    M_AXI_ARVALID = ar_pend;
    M_AXI_AWADDR  = addr_q;
    M_AXI_ARADDR  = addr_q;
    M_AXI_WDATA   = wdata_q;
    M_AXI_AWPROT  = 3'b000;
    M_AXI_ARPROT  = 3'b000;
    M_AXI_WSTRB   = '1;
  end

  // Request payload is only observed while a VALID is high, so it needs no reset.
  always_ff @(posedge ACLK) begin
    if (state == IDLE && any_req) begin
      addr_q  <= {pick_addr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
      wdata_q <= pick_wdata;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      ar_pend    <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      req0_resp  <= 2'b00;
      req1_resp  <= 2'b00;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= pick;
            last_grant <= pick;
            aw_pend    <= pick_write;
            w_pend     <= pick_write;
            ar_pend    <= ~pick_write;
          end
        end
        WR_AW_W: begin
          if (M_AXI_AWREADY) aw_pend <= 1'b0;
          if (M_AXI_WREADY)  w_pend  <= 1'b0;
        end
        WR_B: begin
          if (M_AXI_BVALID) begin
            if (gnt) begin
              req1_done <= 1'b1;
              req1_resp <= M_AXI_BRESP;
            end else begin
              req0_done <= 1'b1;
              req0_resp <= M_AXI_BRESP;
            end
          end
        end
        RD_AR: begin
          if (M_AXI_ARREADY) ar_pend <= 1'b0;
        end
        RD_R: begin
          if (M_AXI_RVALID) begin
            if (gnt) begin
              req1_done  <= 1'b1;
              req1_rdata <= M_AXI_RDATA;
              req1_resp  <= M_AXI_RRESP;
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= M_AXI_RDATA;
              req0_resp  <= M_AXI_RRESP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_encoder_axil_arbiter.sv
// Directed bench for rotary_encoder_axil_arbiter: behavioural AXI4-Lite slave with
// programmable wait states and a scoreboard of expected done events.
module tb_rotary_encoder_axil_arbiter;

  localparam int AW = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
  logic        req0_done, req1_done, busy;
  logic [1:0]  req0_resp, req1_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  rotary_encoder_axil_arbiter #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .req1_resp(req1_resp),
    .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    int          id;
    bit          rd;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sbq[$];
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  task automatic sb_pop(input int id, input logic [31:0] rdata, input logic [1:0] resp);
    exp_t e;
    total++;
    assert (sbq.size() != 0) else begin
      bad++;
      $error("FAIL sb_unexpected_done: observed=done%0d expected=none", id);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("sb_id", id, e.id);
      check("sb_resp", {30'd0, resp}, {30'd0, e.resp});
      if (e.rd) check("sb_rdata", rdata, e.rdata);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESET === 1'b0) begin
      if (req0_done) begin done_cnt0++; sb_pop(0, req0_rdata, req0_resp); end
      if (req1_done) begin done_cnt1++; sb_pop(1, req1_rdata, req1_resp); end
    end
  end

  // Behavioural slave
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [31:0] s_rdata = 32'd0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  int aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, split = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_wstrb, cap_araddr, cap_awprot, cap_arprot;

  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, ar_got;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET !== 1'b0) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
        if (M_AXI_AWVALID !== M_AXI_WVALID) split++;
        if (M_AXI_AWREADY) begin M_AXI_AWREADY = 0; aw_got = 1; aw_beats++; end
        else if (M_AXI_AWVALID) begin
          if (aw_cnt >= aw_wait) begin
            M_AXI_AWREADY = 1; aw_cnt = 0;
            cap_awaddr = {28'd0, M_AXI_AWADDR}; cap_awprot = {29'd0, M_AXI_AWPROT};
          end else aw_cnt++;
        end
        if (M_AXI_WREADY) begin M_AXI_WREADY = 0; w_got = 1; w_beats++; end
        else if (M_AXI_WVALID) begin
          if (w_cnt >= w_wait) begin
            M_AXI_WREADY = 1; w_cnt = 0;
            cap_wdata = M_AXI_WDATA; cap_wstrb = {28'd0, M_AXI_WSTRB};
          end else w_cnt++;
        end
        if (M_AXI_BVALID) begin M_AXI_BVALID = 0; b_beats++; end
        else if (aw_got && w_got) begin
          if (b_cnt >= b_wait) begin
            M_AXI_BVALID = 1; M_AXI_BRESP = s_bresp; b_cnt = 0; aw_got = 0; w_got = 0;
          end else b_cnt++;
        end
        if (M_AXI_ARREADY) begin M_AXI_ARREADY = 0; ar_got = 1; ar_beats++; end
        else if (M_AXI_ARVALID) begin
          if (ar_cnt >= ar_wait) begin
            M_AXI_ARREADY = 1; ar_cnt = 0;
            cap_araddr = {28'd0, M_AXI_ARADDR}; cap_arprot = {29'd0, M_AXI_ARPROT};
          end else ar_cnt++;
        end
        if (M_AXI_RVALID) M_AXI_RVALID = 0;
        else if (ar_got) begin
          if (r_cnt >= r_wait) begin
            M_AXI_RVALID = 1; M_AXI_RDATA = s_rdata; M_AXI_RRESP = s_rresp;
            r_cnt = 0; ar_got = 0;
          end else r_cnt++;
        end
      end
    end
  end

  // One request from a single requester, with latency measured in cycles to done.
  task automatic do_req(input int id, input bit wr, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic [1:0] exp_resp, output int lat);
    exp_t e;
    bit got;
    e.id = id; e.rd = !wr; e.rdata = exp_rd; e.resp = exp_resp;
    sbq.push_back(e);
    @(posedge ACLK); #1;
    if (id == 0) begin req0_valid = 1; req0_write = wr; req0_addr = addr; req0_wdata = wd; end
    else         begin req1_valid = 1; req1_write = wr; req1_addr = addr; req1_wdata = wd; end
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(negedge ACLK);
      lat++;
      if ((id == 0) ? req0_done : req1_done) got = 1;
    end
    if (id == 0) req0_valid = 0; else req1_valid = 0;
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL done_timeout_req%0d: observed=no_done expected=done", id);
    end
  endtask

  initial begin
    int lat, n, cyc, c0, c1, ab, wb, bb, sp;
    bit seen;
    ARESET = 1;
    req0_valid = 1; req0_write = 1; req0_addr = 4'h0; req0_wdata = 32'h11;
    req1_valid = 1; req1_write = 1; req1_addr = 4'h8; req1_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.id = i % 2; e.rd = 0; e.rdata = 32'd0; e.resp = 2'b00;
      sbq.push_back(e);
    end
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_wvalid", M_AXI_WVALID, 0);
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_bready", M_AXI_BREADY, 0);
    check("rst_rready", M_AXI_RREADY, 0);
    check("rst_done0", req0_done, 0);
    check("rst_done1", req1_done, 0);
    check("rst_rdata0", req0_rdata, 0);
    check("rst_rdata1", req1_rdata, 0);
    check("rst_resp0", req0_resp, 0);
    check("rst_resp1", req1_resp, 0);

    // Both requesters held from reset release: four transactions alternate 0,1,0,1.
    ARESET = 0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 400) begin
      @(negedge ACLK);
      cyc++;
      if (req0_done || req1_done) n++;
    end
    req0_valid = 0; req1_valid = 0;
    check("rr_four_done", n, 4);
    repeat (3) @(negedge ACLK);
    check("rr_sb_empty", sbq.size(), 0);
    check("rr_cnt0", done_cnt0, 2);
    check("rr_cnt1", done_cnt1, 2);
    check("rr_idle", busy, 0);

    // req0 write 0x4 <- 0x2, zero-wait slave.
    ab = aw_beats; wb = w_beats;
    do_req(0, 1, 4'h4, 32'h2, 32'h0, 2'b00, lat);
    check("wr_latency", lat, 4);
    @(negedge ACLK);
    check("wr_aw_beats", aw_beats - ab, 1);
    check("wr_w_beats", w_beats - wb, 1);
    check("wr_awaddr", cap_awaddr, 32'h4);
    check("wr_wdata", cap_wdata, 32'h2);
    check("wr_wstrb", cap_wstrb, 32'hF);
    check("wr_awprot", cap_awprot, 0);

    // req1 read 0xC, slave data after 3 wait cycles; req0 stays quiet.
    c0 = done_cnt0;
    r_wait = 3; s_rdata = 32'h4;
    do_req(1, 0, 4'hC, 32'h0, 32'h4, 2'b00, lat);
    r_wait = 0;
    @(negedge ACLK);
    check("rd_rdata1", req1_rdata, 32'h4);
    check("rd_araddr", cap_araddr, 32'hC);
    check("rd_arprot", cap_arprot, 0);
    check("rd_no_done0", done_cnt0, c0);

    // Zero-wait read latency.
    s_rdata = 32'hA5A5_5A5A;
    do_req(0, 0, 4'h8, 32'h0, 32'hA5A5_5A5A, 2'b00, lat);
    check("rd_latency", lat, 4);

    // Unaligned address has its low bits cleared; req1 read data held across a write.
    do_req(1, 1, 4'h7, 32'hDEAD_BEEF, 32'h0, 2'b00, lat);
    @(negedge ACLK);
    check("wr_addr_align", cap_awaddr, 32'h4);
    check("rdata1_hold", req1_rdata, 32'h4);

    // AW accepted before W, then W before AW.
    for (int k = 0; k < 2; k++) begin
      aw_wait = (k == 0) ? 0 : 2;
      w_wait  = (k == 0) ? 2 : 0;
      ab = aw_beats; wb = w_beats; bb = b_beats; sp = split; c0 = done_cnt0;
      do_req(0, 1, 4'h0, 32'h5 + k, 32'h0, 2'b00, lat);
      @(negedge ACLK);
      check(k == 0 ? "aw_first_split" : "w_first_split", split - sp, 2);
      check("split_aw_beats", aw_beats - ab, 1);
      check("split_w_beats", w_beats - wb, 1);
      check("split_b_beats", b_beats - bb, 1);
      check("split_done", done_cnt0 - c0, 1);
    end
    aw_wait = 0; w_wait = 0;

    // SLVERR on read passes through.
    s_rresp = 2'b10; s_rdata = 32'h77;
    do_req(0, 0, 4'h4, 32'h0, 32'h77, 2'b10, lat);
    s_rresp = 2'b00;
    @(negedge ACLK);
    check("slverr_resp0", req0_resp, 2'b10);
    check("slverr_idle", busy, 0);

    // Reset while waiting for B: everything returns to reset values, no done.
    c0 = done_cnt0; c1 = done_cnt1;
    b_wait = 6;
    @(posedge ACLK); #1;
    req0_valid = 1; req0_write = 1; req0_addr = 4'h8; req0_wdata = 32'h99;
    seen = 0; cyc = 0;
    while (!seen && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
      if (M_AXI_BREADY) seen = 1;
    end
    check("rst_mid_reach_wrb", seen, 1);
    #1 ARESET = 1;
    #1;
    check("rst_mid_bready", M_AXI_BREADY, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_awvalid", M_AXI_AWVALID, 0);
    check("rst_mid_wvalid", M_AXI_WVALID, 0);
    check("rst_mid_done0", req0_done, 0);
    check("rst_mid_resp0", req0_resp, 0);
    req0_valid = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 0;
    b_wait = 0;
    repeat (8) @(negedge ACLK);
    check("rst_mid_no_done0", done_cnt0, c0);
    check("rst_mid_no_done1", done_cnt1, c1);

    // Service resumes normally afterwards.
    do_req(1, 1, 4'hC, 32'h3, 32'h0, 2'b00, lat);
    check("post_rst_latency", lat, 4);
    repeat (2) @(negedge ACLK);
    check("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotary_encoder_axil_arbiter.md
ROTARY_ENCODER_AXIL_ARBITER -- requirements
Module: rotary_encoder_axil_arbiter

Interface
REQ-001 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, the register-bank byte address width (four 32-bit registers, offsets 0x0-0xC).
REQ-002 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the data width; only 32 is supported.
REQ-003 ACLK  in  1  single clock; all state updates on its rising edge.
REQ-004 ARESET  in  1  reset, asynchronous assert, active-high.
REQ-005 req0_valid / req1_valid  in  1 each  access request, held until the matching done pulse.
REQ-006 req0_write / req1_write  in  1 each  1 = write, 0 = read.
REQ-007 req0_addr / req1_addr  in  C_S_AXI_ADDR_WIDTH each  byte address.
REQ-008 req0_wdata / req1_wdata  in  32 each  write data.
REQ-009 req0_done / req1_done  out  1 each  one-cycle completion pulse.
REQ-010 req0_rdata / req1_rdata  out  32 each  read data, valid with done.
REQ-011 req0_resp / req1_resp  out  2 each  BRESP or RRESP, valid with done.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 M_AXI_AW*: AWADDR (ADDR_WIDTH) out, AWPROT (3) out, AWVALID out, AWREADY in.
REQ-014 M_AXI_W*: WDATA (32) out, WSTRB (4) out, WVALID out, WREADY in.
REQ-015 M_AXI_B*: BRESP (2) in, BVALID in, BREADY out.
REQ-016 M_AXI_AR*: ARADDR (ADDR_WIDTH) out, ARPROT (3) out, ARVALID out, ARREADY in.
REQ-017 M_AXI_R*: RDATA (32) in, RRESP (2) in, RVALID in, RREADY out.

Function
REQ-018 The FSM SHALL have the states IDLE, WR_AW_W, WR_B, RD_AR and RD_R; one transaction is outstanding at most.
REQ-019 In IDLE with any reqN_valid high, the FSM SHALL latch the grant, write, addr (bits [1:0] forced to 0) and wdata, then go to WR_AW_W or RD_AR on the next edge.
REQ-020 Round-robin: if only one request is valid, that requester SHALL be granted; if both are valid, the requester not granted last SHALL be granted; last_grant updates on each grant.
REQ-021 WR_AW_W SHALL assert AWVALID and WVALID together; each SHALL drop the cycle after its own handshake (VALID&READY); the FSM SHALL go to WR_B once both handshakes are done, in either order or in the same cycle.
REQ-022 WR_B SHALL hold BREADY=1; on BVALID the FSM SHALL capture BRESP, pulse done of the granted requester for one cycle and return to IDLE.
REQ-023 RD_AR SHALL hold ARVALID until ARREADY, then go to RD_R; RD_R SHALL hold RREADY=1 and on RVALID capture RDATA/RRESP, pulse done and return to IDLE.
REQ-024 VALID outputs SHALL never depend combinationally on READY inputs; address and data SHALL stay stable while VALID is high.
REQ-025 AWPROT/ARPROT SHALL be 3'b000 and WSTRB 4'hF.
REQ-026 A request dropped by the requester before done SHALL NOT abort the AXI transaction; the transaction completes and done still pulses.
REQ-027 A non-OKAY response SHALL be passed through unchanged on reqN_resp; no retry.
REQ-028 Minimum latency, valid in IDLE to done pulse, SHALL be 4 cycles for writes and reads with zero-wait slave.
REQ-029 reqN_rdata/reqN_resp SHALL hold their last value until the next done for that requester.

Reset
REQ-030 While ARESET is high, the state SHALL be IDLE, last_grant=1 (req0 wins the first tie), all AXI VALID/READY outputs and done outputs 0, rdata 0, resp 0, busy 0.
REQ-031 Reset asserted mid-transaction SHALL drop all VALID/READY outputs immediately (asynchronously) and discard the pending transaction without a done pulse.

Verification
REQ-032 req0 write addr 0x4, data 0x00000002, zero-wait slave -> one AW/W beat AWADDR=0x4, WDATA=0x2, WSTRB=0xF, then req0_done pulse with resp=00.
REQ-033 req1 read addr 0xC, slave returns RDATA=0x00000004 after 3 wait cycles -> req1_done pulse, req1_rdata=0x4, req0_done stays 0.
REQ-034 req0 and req1 both valid from reset release -> req0 served first, then req1; with both held for 4 transactions -> strict alternation 0,1,0,1.
REQ-035 Write with AWREADY 2 cycles before WREADY, then with the order reversed -> each VALID drops individually, one B handshake, one done.
REQ-036 Read with slave RRESP=10 -> reqN_resp=10 and FSM back in IDLE.
REQ-037 ARESET pulsed while in WR_B -> outputs at reset values within the pulse, no done pulse, next request serviced normally.
